// File: rtl/uart_dump_pkg.sv
// Shared constants for the UART dump engine: FSM encodings and the baud counter width.
package uart_dump_pkg;

    localparam int unsigned BAUD_W = 13;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_SEND = 3'd3;
    localparam logic [2:0] ST_CSUM = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    localparam logic [1:0] PH_IDLE  = 2'd0;
    localparam logic [1:0] PH_START = 2'd1;
    localparam logic [1:0] PH_DATA  = 2'd2;
    localparam logic [1:0] PH_STOP  = 2'd3;

    function automatic logic [BAUD_W-1:0] baud_last(input int unsigned clk_freq,
                                                    input int unsigned bps);
        return BAUD_W'(clk_freq / bps - 1);
    endfunction

endpackage

// File: rtl/delay_buffer.sv
// Fixed-depth shift delay used to synchronise and delay a level enable.
module delay_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] pipe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= {pipe_q[DEPTH-2:0], din};
        end
    end

    assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/uart_tx_byte.sv
// 8N1 LSB-first byte serialiser with its own baud and bit counters.
module uart_tx_byte
    import uart_dump_pkg::*;
#(
    parameter int unsigned BAUD_CNT_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       frame_done
);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_CNT_MAX - 1);

    logic [1:0]        phase_q, phase_d;
    logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              baud_end;
    logic              take;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q    <= PH_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            phase_q    <= phase_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

    always_comb begin
        baud_end   = (baud_cnt_q == BAUD_LAST);
        // A new byte may chain directly onto the last stop-bit cycle.
        take       = load && ((phase_q == PH_IDLE) || ((phase_q == PH_STOP) && baud_end));
        phase_d    = phase_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        baud_cnt_d = ((phase_q == PH_IDLE) || baud_end) ? '0 : baud_cnt_q + 1'b1;
        case (phase_q)
            PH_IDLE:  ;
            PH_START: if (baud_end) phase_d = PH_DATA;
            PH_DATA: begin
                if (baud_end) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    shift_d   = shift_q >> 1;
                    if (bit_cnt_q == 3'd7) phase_d = PH_STOP;
                end
            end
            PH_STOP:  if (baud_end) phase_d = PH_IDLE;
            default:  phase_d = PH_IDLE;
        endcase
        if (take) begin
            phase_d   = PH_START;
            shift_d   = data;
            bit_cnt_d = '0;
        end
        if (clr) begin
            phase_d    = PH_IDLE;
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
            shift_d    = '0;
        end
        case (phase_d)
            PH_START: tx_d = 1'b0;
            PH_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_comb begin
        frame_done = (phase_q == PH_STOP) && baud_end;
        tx         = tx_q;
    end

endmodule

// File: rtl/uart_dump.sv
// UART upload engine: reads words over the RIB bus and sends them as 4 bytes each, LSB first.
// Define UART_DUMP_CSUM_EN to append a mod-256 checksum byte after the last word.
module uart_dump
    import uart_dump_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned UART_BPS = 19200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dump_en_i,
    input  logic        start_i,
    input  logic [31:0] start_addr_i,
    input  logic [15:0] word_num_i,
    output logic        rib_rd_req_o,
    output logic        mem_rd_en_o,
    output logic [31:0] mem_rd_addr_o,
    input  logic [31:0] mem_rd_data_i,
    output logic        uart_tx,
    output logic        busy_o,
    output logic        done_o
);

    localparam int unsigned BAUD_CNT_MAX = CLK_FREQ / UART_BPS;

    logic [2:0]  state_q, state_d;
    logic [31:0] addr_q;
    logic [23:0] rest_q;
    logic [15:0] remain_q;
    logic [1:0]  byte_cnt_q;
    logic        en_d;
    logic        tx_clr;
    logic        load;
    logic [7:0]  load_data;
    logic        frame_done;
`ifdef UART_DUMP_CSUM_EN
    logic [7:0]  csum_q;
`endif

    delay_buffer #(
        .DEPTH(4)
    ) u_en_dly (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (dump_en_i),
        .dout (en_d)
    );

    assign tx_clr = ~en_d;

    uart_tx_byte #(
        .BAUD_CNT_MAX(BAUD_CNT_MAX)
    ) u_tx_byte (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (tx_clr),
        .load      (load),
        .data      (load_data),
        .tx        (uart_tx),
        .frame_done(frame_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        load_data = '0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (word_num_i != 16'd0) begin
                        state_d = ST_RD;
                    end else begin
`ifdef UART_DUMP_CSUM_EN
                        state_d = ST_CSUM;
                        load    = 1'b1;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
            ST_RD:   state_d = ST_WAIT;
            ST_WAIT: begin
                state_d   = ST_SEND;
                load      = 1'b1;
                load_data = mem_rd_data_i[7:0];
            end
            ST_SEND: begin
                if (frame_done) begin
                    if (byte_cnt_q != 2'd3) begin
                        load      = 1'b1;
                        load_data = rest_q[7:0];
                    end else if (remain_q != 16'd1) begin
                        state_d = ST_RD;
                    end else begin
`ifdef UART_DUMP_CSUM_EN
                        state_d   = ST_CSUM;
                        load      = 1'b1;
                        load_data = csum_q;
`else
                        state_d   = ST_DONE;
`endif
                    end
                end
            end
`ifdef UART_DUMP_CSUM_EN
            ST_CSUM: if (frame_done) state_d = ST_DONE;
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // A low delayed enable holds the whole block in its reset state.
        if (!en_d) begin
            state_d = ST_IDLE;
            load    = 1'b0;
        end
    end

    always_comb begin
        busy_o        = (state_q != ST_IDLE);
        rib_rd_req_o  = busy_o;
        mem_rd_en_o   = (state_q == ST_RD);
        mem_rd_addr_o = addr_q;
        done_o        = (state_q == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            rest_q     <= '0;
            remain_q   <= '0;
            byte_cnt_q <= '0;
        end else if (!en_d) begin
            addr_q     <= '0;
            rest_q     <= '0;
            remain_q   <= '0;
            byte_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        addr_q     <= start_addr_i & ~32'h3;
                        remain_q   <= word_num_i;
                        byte_cnt_q <= '0;
                    end
                end
                ST_WAIT: begin
                    rest_q     <= mem_rd_data_i[31:8];
                    byte_cnt_q <= '0;
                end
                ST_SEND: begin
                    if (frame_done) begin
                        if (byte_cnt_q != 2'd3) begin
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                            rest_q     <= rest_q >> 8;
                        end else if (remain_q != 16'd1) begin
                            addr_q   <= addr_q + 32'd4;
                            remain_q <= remain_q - 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef UART_DUMP_CSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else if (!en_d || (state_q == ST_IDLE)) begin
            csum_q <= '0;
        end else if (state_q == ST_WAIT) begin
            csum_q <= csum_q + mem_rd_data_i[7:0];
        end else if ((state_q == ST_SEND) && frame_done && (byte_cnt_q != 2'd3)) begin
            csum_q <= csum_q + rest_q[7:0];
        end
    end
`endif

endmodule
